tlb_fill_writer: RTL

//  Write side of the TLB: takes a leaf PTE returned by the page-table walker, checks superpage

---
 rtl/tlb_fill_writer_pkg.sv | 41 ++++
 rtl/tlb_fill_writer_if.sv | 36 +++
 rtl/tlb_fill_writer_victim_sel.sv | 38 +++
 rtl/tlb_fill_writer.sv | 109 ++++++++++
 4 files changed

// File: rtl/tlb_fill_writer_pkg.sv
// Shared TLB fill definitions: page-type encoding and superpage alignment masks,
// also used by the read-side PPN/VPN mixer.
package tlb_fill_writer_pkg;

  typedef logic [1:0] page_type_t;

  localparam page_type_t KILO = 2'd0;
  localparam page_type_t MEGA = 2'd1;
  localparam page_type_t GIGA = 2'd2;
  localparam page_type_t TERA = 2'd3;

  localparam logic [63:0] MASK32_MEGA = 64'h3FF;
  localparam logic [63:0] MASK64_MEGA = 64'h1FF;
  localparam logic [63:0] MASK64_GIGA = 64'h3FFFF;
  localparam logic [63:0] MASK64_TERA = 64'h7FFFFFF;

  // Sv32 has no giga/tera pages, so those types can never be installed.
  function automatic logic superpage_misaligned(input int xlen, input page_type_t ptype,
                                                input logic [63:0] ppn);
    logic [63:0] mask;
    logic        illegal;
    mask    = '0;
    illegal = 1'b0;
    if (xlen == 32) begin
      case (ptype)
        MEGA:       mask    = MASK32_MEGA;
        GIGA, TERA: illegal = 1'b1;
        default:    mask    = '0;
      endcase
    end else begin
      case (ptype)
        MEGA:    mask = MASK64_MEGA;
        GIGA:    mask = MASK64_GIGA;
        TERA:    mask = MASK64_TERA;
        default: mask = '0;
      endcase
    end
    return illegal || ((ppn & mask) != '0);
  endfunction

endpackage

// File: rtl/tlb_fill_writer_if.sv
// Fill channel from the page-table walker plus the write port into the TLB entry arrays.
interface tlb_fill_if
  import tlb_fill_writer_pkg::*;
#(
  parameter int VPN_BITS    = 27,
  parameter int PPN_BITS    = 44,
  parameter int ASID_BITS   = 16,
  parameter int TLB_ENTRIES = 8
);
  logic                   FillValid;
  logic                   FillReady;
  logic [VPN_BITS-1:0]    FillVPN;
  logic [PPN_BITS-1:0]    FillPPN;
  page_type_t             FillPageType;
  logic [7:0]             FillFlags;
  logic [ASID_BITS-1:0]   FillASID;
  logic [TLB_ENTRIES-1:0] EntryValid;
  logic                   SFenceVMA;
  logic [TLB_ENTRIES-1:0] WriteEn;
  logic [VPN_BITS-1:0]    WriteVPN;
  logic [PPN_BITS-1:0]    WritePPN;
  page_type_t             WritePageType;
  logic [7:0]             WriteFlags;
  logic [ASID_BITS-1:0]   WriteASID;
  logic                   Misaligned;

  modport master (
    output FillValid, FillVPN, FillPPN, FillPageType, FillFlags, FillASID, EntryValid, SFenceVMA,
    input  FillReady, WriteEn, WriteVPN, WritePPN, WritePageType, WriteFlags, WriteASID, Misaligned
  );

  modport slave (
    input  FillValid, FillVPN, FillPPN, FillPageType, FillFlags, FillASID, EntryValid, SFenceVMA,
    output FillReady, WriteEn, WriteVPN, WritePPN, WritePageType, WriteFlags, WriteASID, Misaligned
  );
endinterface

// File: rtl/tlb_fill_writer_victim_sel.sv
// Victim selection: lowest free entry, else the round-robin pointer (advanced only
// when a pointer-chosen entry is actually written).
module tlb_victim_sel #(
  parameter int TLB_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TLB_ENTRIES-1:0] entry_valid,
  input  logic                   advance,
  output logic [TLB_ENTRIES-1:0] victim,
  output logic                   use_ptr
);
  localparam int PW = $clog2(TLB_ENTRIES);
  localparam logic [TLB_ENTRIES-1:0] ONE = TLB_ENTRIES'(1);

  logic [PW-1:0]          ptr;
  logic [TLB_ENTRIES-1:0] free_onehot;

  // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    free_onehot = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid[i]) begin
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
  end

  assign use_ptr = &entry_valid;
  assign victim  = use_ptr ? (ONE << ptr) : free_onehot;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)        ptr <= '0;
    else if (advance) ptr <= ptr + PW'(1);
  end
endmodule

// File: rtl/tlb_fill_writer.sv
// TLB write side: captures a leaf PTE, checks superpage alignment, picks a victim and
// issues a one-cycle entry write or a misaligned-superpage fault pulse.
module tlb_fill_writer
  import tlb_fill_writer_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int VPN_BITS    = 27,
  parameter int PPN_BITS    = 44,
  parameter int ASID_BITS   = 16,
  parameter int TLB_ENTRIES = 8
) (
  input logic     clk,
  input logic     reset,
  tlb_fill_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITE, FAULT} state_t;

  state_t                 state, state_n;
  logic                   accept;
  logic                   misaligned_chk;
  logic                   advance;
  logic                   use_ptr, use_ptr_q;
  logic [TLB_ENTRIES-1:0] victim, victim_q;
  logic [VPN_BITS-1:0]    vpn_q;
  logic [PPN_BITS-1:0]    ppn_q;
  page_type_t             ptype_q;
  logic [7:0]             flags_q;
  logic [ASID_BITS-1:0]   asid_q;

  assign accept         = (state == IDLE) && bus.FillValid && !bus.SFenceVMA;
  assign misaligned_chk = superpage_misaligned(XLEN, ptype_q, 64'(ppn_q));
  assign advance        = (state == WRITE) && !bus.SFenceVMA && use_ptr_q;

  tlb_victim_sel #(.TLB_ENTRIES(TLB_ENTRIES)) u_victim (
    .clk         (clk),
    .reset       (reset),
    .entry_valid (bus.EntryValid),
    .advance     (advance),
    .victim      (victim),
    .use_ptr     (use_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A flush overrides everything: in-flight fills are dropped without side effects.
  always_comb begin
    state_n        = state;
    bus.FillReady  = 1'b0;
    bus.WriteEn    = '0;
    bus.Misaligned = 1'b0;
    case (state)
      IDLE: begin
        bus.FillReady = !bus.SFenceVMA;
        if (accept) state_n = CHECK;
      end
      CHECK: begin
        if (bus.SFenceVMA)   state_n = IDLE;
        else if (misaligned_chk) state_n = FAULT;
        else                 state_n = WRITE;
      end
      WRITE: begin
        if (!bus.SFenceVMA) bus.WriteEn = victim_q;
        state_n = IDLE;
      end
      FAULT: begin
        bus.Misaligned = !bus.SFenceVMA;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the capture registers are reset so the write bus is clean after reset, not just idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpn_q   <= '0;
      ppn_q   <= '0;
      ptype_q <= KILO;
      flags_q <= '0;
      asid_q  <= '0;
    end else if (accept) begin
      vpn_q   <= bus.FillVPN;
      ppn_q   <= bus.FillPPN;
      ptype_q <= bus.FillPageType;
      flags_q <= bus.FillFlags;
      asid_q  <= bus.FillASID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      victim_q  <= '0;
      use_ptr_q <= 1'b0;
    end else if (state == CHECK && !bus.SFenceVMA) begin
      victim_q  <= victim;
      use_ptr_q <= use_ptr;
    end
  end

  // PPN goes out unmodified; offset bits are merged with the VPN on the read side.
  assign bus.WriteVPN      = vpn_q;
  assign bus.WritePPN      = ppn_q;
  assign bus.WritePageType = ptype_q;
  assign bus.WriteFlags    = flags_q;
  assign bus.WriteASID     = asid_q;
endmodule
